// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the memory-manager bus path.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bm_state_t;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } bm_src_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/bm_timeout_counter.sv
// Counts BUS cycles and flags the terminal count for the abort path.
module bm_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_master_if.sv
// Arbitrating single-transfer Wishbone-classic master for fetch and data.
// Optional bus timeout abort: define BUS_MASTER_TIMEOUT_EN.
module bus_master_if
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_req,
    input  logic [ADDR_W-1:0]   instr_addr,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_sel,
    output logic                bus_full,
    output logic [DATA_W-1:0]   instr_rdata,
    output logic                instr_valid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_valid,
    output logic                err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i
);

    bm_state_t state;
    bm_src_t   src;
    logic      tmo;
    logic      data_req;

    assign data_req = data_read | data_write;

`ifdef BUS_MASTER_TIMEOUT_EN
    logic expired;

    bm_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .en     (state == BUS),
        .expired(expired)
    );

    // A same-cycle ack beats the terminal count.
    assign tmo = expired & ~wb_ack_i;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src         <= SRC_INSTR;
            bus_full    <= 1'b0;
            instr_rdata <= '0;
            instr_valid <= 1'b0;
            data_rdata  <= '0;
            data_valid  <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
            err         <= 1'b0;
`endif
        end else begin
            instr_valid <= 1'b0;
            data_valid  <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
            err         <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        state    <= BUS;
                        bus_full <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        if (data_req) begin
                            src      <= SRC_DATA;
                            wb_we_o  <= data_write;
                            wb_adr_o <= data_addr;
                            wb_dat_o <= data_wdata;
                            wb_sel_o <= data_sel;
                        end else begin
                            src      <= SRC_INSTR;
                            wb_we_o  <= 1'b0;
                            wb_adr_o <= instr_addr;
                            wb_dat_o <= '0;
                            wb_sel_o <= '1;
                        end
                    end
                end
                BUS: begin
                    if (wb_ack_i || tmo) begin
                        state    <= DONE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
                        err      <= tmo;
`endif
                        if (src == SRC_DATA) begin
                            data_valid <= 1'b1;
                            if (!wb_we_o) begin
                                data_rdata <= tmo ? '0 : wb_dat_i;
                            end
                        end else begin
                            instr_valid <= 1'b1;
                            instr_rdata <= tmo ? '0 : wb_dat_i;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus_full <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus_full <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: vector table plus scoreboard.
module tb_bus_master_if;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_sel;
    logic        bus_full;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    bus_master_if #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .data_read(data_read), .data_write(data_write),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_sel(data_sel), .bus_full(bus_full),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid),
        .data_rdata(data_rdata), .data_valid(data_valid),
        .err(err), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] bus_data;
        int          waits;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [31:0] ir;
        logic [31:0] dr;
        logic        err;
    } exp_t;

    localparam logic [1:0] K_INSTR = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];
    logic [31:0] m_ir = '0;
    logic [31:0] m_dr = '0;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic push(input logic is_data, input logic e);
        exp_t x;
        x.is_data = is_data;
        x.ir = m_ir;
        x.dr = m_dr;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
    endtask

    // Scoreboard: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (instr_valid || data_valid)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got i=%b d=%b expected none",
                         instr_valid, data_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_src", {30'd0, instr_valid, data_valid},
                    e.is_data ? 32'd1 : 32'd2);
                chk("instr_rdata", instr_rdata, e.ir);
                chk("data_rdata", data_rdata, e.dr);
                chk("err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    task automatic run_txn(input vec_t v);
        logic [31:0] want_adr;
        instr_req  = (v.kind == K_INSTR);
        data_read  = (v.kind == K_READ);
        data_write = (v.kind == K_WRITE);
        instr_addr = v.addr;
        data_addr  = v.addr;
        data_wdata = v.wdata;
        data_sel   = v.sel;
        want_adr   = v.addr;
        if (v.kind == K_INSTR) m_ir = v.bus_data;
        if (v.kind == K_READ) m_dr = v.bus_data;
        push(v.kind != K_INSTR, 1'b0);
        step();
        idle_inputs();
        data_wdata = $urandom;
        data_addr  = $urandom;
        instr_addr = $urandom;
        for (int i = 0; i <= v.waits; i++) begin
            chk("cyc", {31'd0, wb_cyc_o}, 32'd1);
            chk("stb", {31'd0, wb_stb_o}, 32'd1);
            chk("we", {31'd0, wb_we_o}, {31'd0, v.kind == K_WRITE});
            chk("adr", wb_adr_o, want_adr);
            chk("busy", {31'd0, bus_full}, 32'd1);
            if (v.kind == K_WRITE) begin
                chk("wdat", wb_dat_o, v.wdata);
                chk("wsel", {28'd0, wb_sel_o}, {28'd0, v.sel});
            end
            wb_ack_i = (i == v.waits);
            wb_dat_i = (i == v.waits) ? v.bus_data : $urandom;
            step();
        end
        wb_ack_i = 1'b0;
        chk("done_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("done_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("done_busy", {31'd0, bus_full}, 32'd1);
        step();
        chk("idle_busy", {31'd0, bus_full}, 32'd0);
        chk("idle_valid", {30'd0, instr_valid, data_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{K_INSTR, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0};
        vecs[1] = '{K_WRITE, 32'h2000, 32'h12345678, 4'b0011, 32'h0BAD0BAD, 3};
        vecs[2] = '{K_READ, 32'h3004, 32'h0, 4'hF, 32'hCAFEF00D, 1};
        vecs[3] = '{K_INSTR, 32'h104, 32'h0, 4'h0, 32'h0BADF00D, 2};
        vecs[4] = '{K_WRITE, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 32'h1, 0};
        vecs[5] = '{K_READ, 32'h10, 32'h0, 4'b1000, 32'hA5A5A5A5, 0};
        vecs[6] = '{K_WRITE, 32'h0, 32'h0, 4'b0100, 32'h5A5A5A5A, 5};

        rst = 1'b1;
        idle_inputs();
        instr_addr = '0;
        data_addr  = '0;
        data_wdata = '0;
        data_sel   = '0;
        wb_dat_i   = '0;
        wb_ack_i   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        chk("rst_busy", {31'd0, bus_full}, 32'd0);
        chk("rst_cyc", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        chk("rst_rdata", instr_rdata | data_rdata, 32'd0);
        chk("rst_flags", {29'd0, instr_valid, data_valid, err}, 32'd0);

        for (int n = 0; n < 7; n++) run_txn(vecs[n]);

        // Spurious ack while idle must be ignored.
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h99999999;
        step();
        step();
        wb_ack_i = 1'b0;
        chk("spur_busy", {31'd0, bus_full}, 32'd0);
        chk("spur_cyc", {31'd0, wb_cyc_o}, 32'd0);

        // Simultaneous fetch and load: load first, fetch after bus frees.
        instr_req  = 1'b1;
        instr_addr = 32'h400;
        data_read  = 1'b1;
        data_addr  = 32'h500;
        m_dr = 32'h11111111;
        push(1'b1, 1'b0);
        m_ir = 32'h22222222;
        push(1'b0, 1'b0);
        step();
        data_read = 1'b0;
        chk("pri_adr", wb_adr_o, 32'h500);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h11111111;
        step();
        wb_ack_i = 1'b0;
        step();
        chk("pri_free", {31'd0, bus_full}, 32'd0);
        chk("pri_gap", {31'd0, wb_cyc_o}, 32'd0);
        step();
        chk("pri_cyc2", {31'd0, wb_cyc_o}, 32'd1);
        chk("pri_adr2", wb_adr_o, 32'h400);
        instr_req = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h22222222;
        step();
        wb_ack_i = 1'b0;
        step();
        step();

        // Read and write together: write wins.
        data_read  = 1'b1;
        data_write = 1'b1;
        data_addr  = 32'h600;
        data_wdata = 32'h55;
        data_sel   = 4'hF;
        push(1'b1, 1'b0);
        step();
        idle_inputs();
        chk("ww_we", {31'd0, wb_we_o}, 32'd1);
        chk("ww_dat", wb_dat_o, 32'h55);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h77777777;
        step();
        wb_ack_i = 1'b0;
        step();
        step();

        // Reset in the second BUS cycle aborts without a valid pulse.
        data_read = 1'b1;
        data_addr = 32'h700;
        step();
        idle_inputs();
        step();
        chk("mid_cyc_pre", {31'd0, wb_cyc_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ir = '0;
        m_dr = '0;
        chk("mid_cyc", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        chk("mid_busy", {31'd0, bus_full}, 32'd0);
        chk("mid_rdata", instr_rdata | data_rdata, 32'd0);
        chk("mid_bus", wb_adr_o | wb_dat_o | {28'd0, wb_sel_o}, 32'd0);
        chk("mid_flags", {29'd0, instr_valid, data_valid, err}, 32'd0);
        step();
        chk("mid_idle", {31'd0, wb_cyc_o}, 32'd0);

`ifdef BUS_MASTER_TIMEOUT_EN
        begin
            int cnt;
            m_dr = 32'h31313131;
            run_txn('{K_READ, 32'h880, 32'h0, 4'hF, 32'h31313131, 0});
            data_read = 1'b1;
            data_addr = 32'h800;
            m_dr = '0;
            push(1'b1, 1'b1);
            step();
            idle_inputs();
            cnt = 0;
            while (wb_cyc_o && cnt < 40) begin
                cnt++;
                step();
            end
            chk("tmo_cycles", cnt, TMO);
            step();
            step();
            data_read = 1'b1;
            data_addr = 32'h900;
            m_dr = 32'h77;
            push(1'b1, 1'b0);
            step();
            idle_inputs();
            repeat (TMO - 1) step();
            chk("tc_cyc", {31'd0, wb_cyc_o}, 32'd1);
            wb_ack_i = 1'b1;
            wb_dat_i = 32'h77;
            step();
            wb_ack_i = 1'b0;
            chk("tc_done", {31'd0, wb_cyc_o}, 32'd0);
            step();
            step();
        end
`else
        begin
            vec_t lng;
            lng = '{K_READ, 32'hA00, 32'h0, 4'hF, 32'h600DCAFE, 90};
            run_txn(lng);
            chk("err_tied", {31'd0, err}, 32'd0);
        end
`endif

        step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
